// File: rtl/apuf_xor_eval.sv
// Sequencer for K parallel N-stage arbiter PUF chains: repeated races, per-chain majority vote, XOR response.
// Optional APUF_STABILITY_EN adds resp_stable/all_stable outputs flagging chains whose samples all agreed.
module apuf_xor_eval #(
  parameter int N      = 128,
  parameter int K      = 4,
  parameter int REPS   = 5,
  parameter int SETTLE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         chal_valid,
  output logic         chal_ready,
  input  logic [N-1:0] challenge,
  output logic [N-1:0] puf_sel,
  output logic         puf_launch,
  output logic         puf_arb_reset,
  input  logic [K-1:0] puf_out,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         response,
  output logic [K-1:0] chain_bits
`ifdef APUF_STABILITY_EN
  ,
  output logic [K-1:0] resp_stable,
  output logic         all_stable
`endif
);

  localparam int unsigned REP_W  = (REPS > 1) ? $clog2(REPS) : 1;
  localparam int unsigned SET_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned ONES_W = $clog2(REPS + 1);

  if ((REPS < 1) || ((REPS % 2) == 0)) begin : g_bad_reps
    $error("apuf_xor_eval: REPS must be odd and >= 1");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("apuf_xor_eval: SETTLE must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LAUNCH, S_SAMPLE, S_VOTE, S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [N-1:0]                   puf_sel_q, puf_sel_d;
  logic [REP_W-1:0]               rep_q, rep_d;
  logic [SET_W-1:0]               settle_q, settle_d;
  logic [K-1:0][ONES_W-1:0]       ones_q, ones_d;
  logic [K-1:0]                   chain_bits_q, chain_bits_d;
  logic                           response_q, response_d;
  logic                           chal_ready_q, chal_ready_d;
  logic                           launch_q, launch_d;
  logic                           arb_reset_q, arb_reset_d;
  logic                           resp_valid_q, resp_valid_d;
`ifdef APUF_STABILITY_EN
  logic [K-1:0]                   stable_q, stable_d;
  logic                           all_stable_q, all_stable_d;
`endif

  // Next-state, datapath and next-cycle control outputs
  always_comb begin
    state_d      = state_q;
    puf_sel_d    = puf_sel_q;
    rep_d        = rep_q;
    settle_d     = settle_q;
    ones_d       = ones_q;
    chain_bits_d = chain_bits_q;
    response_d   = response_q;
`ifdef APUF_STABILITY_EN
    stable_d     = stable_q;
    all_stable_d = all_stable_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (chal_valid && chal_ready_q) begin
          puf_sel_d = challenge;
          rep_d     = '0;
          ones_d    = '0;
          state_d   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        settle_d = '0;
        state_d  = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        for (int k = 0; k < K; k++) begin
          ones_d[k] = ones_q[k] + ONES_W'(puf_out[k]);
        end
        if (rep_q == REP_W'(REPS - 1)) begin
          state_d = S_VOTE;
        end else begin
          rep_d   = rep_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_VOTE: begin
        for (int k = 0; k < K; k++) begin
          chain_bits_d[k] = (ones_q[k] > ONES_W'(REPS / 2));
`ifdef APUF_STABILITY_EN
          stable_d[k] = (ones_q[k] == '0) || (ones_q[k] == ONES_W'(REPS));
`endif
        end
        response_d = ^chain_bits_d;
`ifdef APUF_STABILITY_EN
        all_stable_d = &stable_d;
`endif
        state_d = S_DONE;
      end
      S_DONE: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Control outputs are registered, so decode them from the upcoming state
    chal_ready_d = (state_d == S_IDLE);
    launch_d     = (state_d == S_LAUNCH) || (state_d == S_SAMPLE);
    arb_reset_d  = !launch_d;
    resp_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      puf_sel_q    <= '0;
      rep_q        <= '0;
      settle_q     <= '0;
      ones_q       <= '0;
      chain_bits_q <= '0;
      response_q   <= 1'b0;
      chal_ready_q <= 1'b0;
      launch_q     <= 1'b0;
      arb_reset_q  <= 1'b1;
      resp_valid_q <= 1'b0;
`ifdef APUF_STABILITY_EN
      stable_q     <= '0;
      all_stable_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      puf_sel_q    <= puf_sel_d;
      rep_q        <= rep_d;
      settle_q     <= settle_d;
      ones_q       <= ones_d;
      chain_bits_q <= chain_bits_d;
      response_q   <= response_d;
      chal_ready_q <= chal_ready_d;
      launch_q     <= launch_d;
      arb_reset_q  <= arb_reset_d;
      resp_valid_q <= resp_valid_d;
`ifdef APUF_STABILITY_EN
      stable_q     <= stable_d;
      all_stable_q <= all_stable_d;
`endif
    end
  end

  assign chal_ready    = chal_ready_q;
  assign puf_sel       = puf_sel_q;
  assign puf_launch    = launch_q;
  assign puf_arb_reset = arb_reset_q;
  assign resp_valid    = resp_valid_q;
  assign response      = response_q;
  assign chain_bits    = chain_bits_q;
`ifdef APUF_STABILITY_EN
  assign resp_stable   = stable_q;
  assign all_stable    = all_stable_q;
`endif

endmodule

// File: tb/tb_apuf_xor_eval.sv
// Self-checking bench for apuf_xor_eval (N=8, K=2, REPS=3, SETTLE=2); checks stability outputs when APUF_STABILITY_EN is set.
module tb_apuf_xor_eval;

  localparam int N      = 8;
  localparam int K      = 2;
  localparam int REPS   = 3;
  localparam int SETTLE = 2;
  localparam int LAT    = REPS * (SETTLE + 2) + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         chal_valid;
  logic         chal_ready;
  logic [N-1:0] challenge;
  logic [N-1:0] puf_sel;
  logic         puf_launch;
  logic         puf_arb_reset;
  logic [K-1:0] puf_out;
  logic         resp_valid;
  logic         resp_ready;
  logic         response;
  logic [K-1:0] chain_bits;
`ifdef APUF_STABILITY_EN
  logic [K-1:0] resp_stable;
  logic         all_stable;
`endif

  always #5 clk = ~clk;

  apuf_xor_eval #(.N(N), .K(K), .REPS(REPS), .SETTLE(SETTLE)) dut (
    .clk           (clk),
    .reset         (reset),
    .chal_valid    (chal_valid),
    .chal_ready    (chal_ready),
    .challenge     (challenge),
    .puf_sel       (puf_sel),
    .puf_launch    (puf_launch),
    .puf_arb_reset (puf_arb_reset),
    .puf_out       (puf_out),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .response      (response),
    .chain_bits    (chain_bits)
`ifdef APUF_STABILITY_EN
    ,
    .resp_stable   (resp_stable),
    .all_stable    (all_stable)
`endif
  );

  typedef struct {
    logic [N-1:0]      chal;
    logic [REPS*K-1:0] samples;   // rep r in bits [r*K +: K]
    logic [K-1:0]      exp_bits;
    logic              exp_resp;
    logic [K-1:0]      exp_stable;
    int                hold;
    bit                poke;
  } vec_t;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [K-1:0] samp [REPS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: count ones per chain, strict majority, parity of the number of voted ones
  function automatic void model(output logic [K-1:0] bits, output logic resp,
                                output logic [K-1:0] stab);
    int cnt;
    int nb;
    nb = 0;
    for (int k = 0; k < K; k++) begin
      cnt = 0;
      for (int r = 0; r < REPS; r++) if (samp[r][k]) cnt++;
      bits[k] = (2 * cnt > REPS);
      stab[k] = (cnt == 0) || (cnt == REPS);
      if (bits[k]) nb++;
    end
    resp = (nb % 2) == 1;
  endfunction

  task automatic run_eval(input logic [N-1:0] ch, input logic [K-1:0] eb, input logic er,
                          input logic [K-1:0] es, input int hold, input bit poke);
    int   n, lat, rep, run;
    logic pl, pa;
    n = 0;
    while (!chal_ready && n < 50) begin step(); n++; end
    chk("ready_before_accept", 32'(chal_ready), 32'd1);
    challenge  = ch;
    chal_valid = 1'b1;
    step();
    chal_valid = 1'b0;
    challenge  = ~ch;
    chk("puf_sel_capture", 32'(puf_sel), 32'(ch));
    lat = 0; rep = 0; run = 0; pl = 1'b0; pa = 1'b1;
    while (!resp_valid && lat < 4 * LAT) begin
      if (puf_launch && !pl) begin
        chk("clear_before_launch", 32'(pa), 32'd1);
        if (rep < REPS) puf_out = samp[rep];
        rep++;
      end
      if (puf_launch) begin
        run++;
        chk("arb_low_in_launch", 32'(puf_arb_reset), 32'd0);
      end else begin
        if (pl) begin
          chk("launch_len", 32'(run), 32'(SETTLE + 1));
          run = 0;
        end
        puf_out = K'($urandom);
      end
      if (poke && lat == 4) begin
        chal_valid = 1'b1;
        challenge  = ch ^ 8'h3C;
      end else begin
        chal_valid = 1'b0;
      end
      chk("ready_low_busy", 32'(chal_ready), 32'd0);
      pl = puf_launch;
      pa = puf_arb_reset;
      step();
      lat++;
    end
    chal_valid = 1'b0;
    chk("latency", 32'(lat), 32'(LAT));
    chk("launch_count", 32'(rep), 32'(REPS));
    chk("puf_sel_held", 32'(puf_sel), 32'(ch));
    chk("chain_bits", 32'(chain_bits), 32'(eb));
    chk("response", 32'(response), 32'(er));
`ifdef APUF_STABILITY_EN
    chk("resp_stable", 32'(resp_stable), 32'(es));
    chk("all_stable", 32'(all_stable), 32'(&es));
`else
    if (es === 'x) $display("unexpected X stability vector");
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_bits", 32'(chain_bits), 32'(eb));
      chk("hold_resp", 32'(response), 32'(er));
      chk("hold_ready_low", 32'(chal_ready), 32'd0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("valid_drop", 32'(resp_valid), 32'd0);
    chk("ready_after_hs", 32'(chal_ready), 32'd1);
    chk("bits_kept", 32'(chain_bits), 32'(eb));
    chk("resp_kept", 32'(response), 32'(er));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t         tbl [6];
    logic [K-1:0] eb, es;
    logic         er;
    int           n, rises;
    logic         pl;

    tbl[0] = '{8'hA5, 6'b01_01_01, 2'b01, 1'b1, 2'b11, 0, 1'b0};
    tbl[1] = '{8'h3C, 6'b11_10_01, 2'b11, 1'b0, 2'b00, 10, 1'b1};
    tbl[2] = '{8'h00, 6'b00_00_00, 2'b00, 1'b0, 2'b11, 1, 1'b0};
    tbl[3] = '{8'hFF, 6'b11_11_11, 2'b11, 1'b0, 2'b11, 0, 1'b0};
    tbl[4] = '{8'h5A, 6'b10_00_10, 2'b10, 1'b1, 2'b01, 2, 1'b1};
    tbl[5] = '{8'h81, 6'b00_10_11, 2'b10, 1'b1, 2'b00, 0, 1'b0};

    reset = 1'b1; chal_valid = 1'b0; challenge = '0; puf_out = '0; resp_ready = 1'b0;
    step();
    step();
    chk("rst_ctrl", 32'({chal_ready, puf_arb_reset, puf_launch, resp_valid}), 32'b0100);
    chk("rst_sel", 32'(puf_sel), 32'd0);
    chk("rst_out", 32'({chain_bits, response}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chal_valid = 1'b0;
      chk("idle_static", 32'({chal_ready, puf_arb_reset, puf_launch, resp_valid}), 32'b1100);
    end

    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < REPS; r++) samp[r] = tbl[v].samples[r*K +: K];
      run_eval(tbl[v].chal, tbl[v].exp_bits, tbl[v].exp_resp, tbl[v].exp_stable,
               tbl[v].hold, tbl[v].poke);
    end

    for (int v = 0; v < 12; v++) begin
      for (int r = 0; r < REPS; r++) samp[r] = K'($urandom);
      model(eb, er, es);
      run_eval(N'($urandom), eb, er, es, int'($urandom_range(0, 3)), v[0]);
    end

    // Abort during the second launch window, then confirm counts start fresh
    for (int r = 0; r < REPS; r++) samp[r] = '1;
    challenge = 8'h77; chal_valid = 1'b1;
    step();
    chal_valid = 1'b0;
    n = 0; rises = 0; pl = 1'b0;
    while (n < 100) begin
      if (puf_launch && !pl) begin
        rises++;
        if (rises == 2) break;
      end
      pl = puf_launch;
      puf_out = '1;
      step();
      n++;
    end
    chk("mid_reach_launch2", 32'(rises), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'({chal_ready, puf_arb_reset, puf_launch, resp_valid}), 32'b0100);
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("post_abort_idle", 32'({chal_ready, puf_arb_reset, puf_launch, resp_valid}), 32'b1100);
    end
    samp[0] = 2'b00; samp[1] = 2'b00; samp[2] = 2'b01;
    run_eval(8'hC3, 2'b00, 1'b0, 2'b10, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apuf_xor_eval.md
Name: apuf_xor_eval

Overview:
- Sequencing controller for K parallel N-stage arbiter PUF chains (XOR arbiter PUF).
- Accepts one challenge per handshake and drives the challenge to all chains, then runs REPS race evaluations (arbiter clear, launch, settle, sample).
- Majority-votes each chain's REPS samples, XORs the K voted bits into one response bit, and returns it over a valid/ready handshake.
- Sits between the challenge source and the chain/arbiter instances, which stay external and are reached through the puf_* ports.

Parameters:
- N, 128, stages per chain; width of challenge and puf_sel.
- K, 4, number of parallel chains XORed into the response.
- REPS, 5, evaluations per challenge. Must be odd and >=1; elaboration error otherwise.
- SETTLE, 4, cycles launch is held high before sampling. Must be >=1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  controller can accept a challenge.
- challenge  in  N  challenge bits; captured on accept.
- puf_sel  out  N  registered challenge to every chain's stage selects.
- puf_launch  out  1  race launch edge into all chains.
- puf_arb_reset  out  1  clears all K arbiter latches.
- puf_out  in  K  arbiter latch outputs, one per chain.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- response  out  1  XOR of the K majority bits.
- chain_bits  out  K  per-chain majority bits (debug/modelling).

Behaviour:
- Reset, asynchronous: state=IDLE; puf_sel, chain_bits, response, rep counter and ones counters = 0; puf_launch=0; puf_arb_reset=1; chal_ready=0 while reset is asserted and 1 from the first edge after deassertion; resp_valid=0.
- Reset asserted in any state aborts the evaluation immediately. No partial response is ever emitted.
- States: IDLE, CLEAR, LAUNCH, SAMPLE, VOTE, DONE.
- IDLE:
  - chal_ready=1, puf_arb_reset=1, puf_launch=0.
  - On chal_valid&&chal_ready: puf_sel<=challenge; rep<=0; ones[k]<=0; go to CLEAR.
- CLEAR:
  - 1 cycle; puf_arb_reset=1, puf_launch=0; go to LAUNCH.
- LAUNCH:
  - puf_arb_reset=0, puf_launch=1, held exactly SETTLE cycles (settle counter); then go to SAMPLE.
- SAMPLE:
  - 1 cycle; puf_launch=1; ones[k]<=ones[k]+puf_out[k] for every k.
  - If rep==REPS-1 go to VOTE; else rep<=rep+1 and go to CLEAR.
- VOTE:
  - 1 cycle; chain_bits[k]<=(ones[k] > REPS/2); response<=^ of the new chain_bits; go to DONE.
- DONE:
  - resp_valid=1; response and chain_bits held stable.
  - On resp_ready go to IDLE; resp_valid drops the next cycle.
- Latency: resp_valid first high exactly REPS*(SETTLE+2)+1 cycles after the accept edge (31 at defaults).
- Ones counters are $clog2(REPS+1) bits wide and cannot overflow.
- puf_sel changes only on an accept edge, never mid-evaluation.
- chal_valid is ignored outside IDLE (chal_ready=0). No challenge buffering.
- resp_ready while resp_valid=0 is ignored.
- Back-to-back: the earliest next accept is the cycle after the DONE handshake.
- chain_bits and response keep their last values after DONE until the next VOTE.
- puf_out is sampled only in SAMPLE; its value in other states is don't-care.

Optional Feature:
- Macro APUF_STABILITY_EN.
- Defined:
  - Extra output port resp_stable, width K. Bit k=1 iff ones[k]==0 or ones[k]==REPS, i.e. all REPS samples agreed.
  - Updated in VOTE alongside chain_bits; reset value 0.
  - Extra output all_stable = &resp_stable.
- Undefined: neither port exists and no stability logic is built. All other behaviour is identical.

Test Plan:
- Bench params N=8, K=2, REPS=3, SETTLE=2; expected latency 13.
- Reset then idle: after reset deasserts, chal_ready=1, puf_arb_reset=1, puf_launch=0, resp_valid=0; outputs stay static for 20 cycles.
- Stable chains: challenge=8'hA5, model puf_out=2'b01 every sample -> puf_sel=8'hA5; resp_valid exactly 13 cycles after accept; chain_bits=2'b01; response=1; with APUF_STABILITY_EN, resp_stable=2'b11.
- Majority vote: puf_out chain0 samples 1,0,1 and chain1 samples 0,1,1 -> chain_bits=2'b11; response=0; with macro, resp_stable=2'b00.
- Backpressure: resp_ready held low 10 cycles after resp_valid -> response and chain_bits stable and chal_ready=0 throughout; on handshake, chal_ready=1 the next cycle; a chal_valid pulse during the evaluation is not accepted.
- Waveform sequence per rep: 1 cycle puf_arb_reset=1 with launch=0, then 3 cycles launch=1 (SETTLE plus SAMPLE) -> exactly 3 launch pulses per challenge.
- Reset mid-operation: assert reset during the second LAUNCH -> state IDLE, puf_launch=0, puf_arb_reset=1, resp_valid never asserts; the next challenge completes normally with fresh counts.
